memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 SHALL have parameter ISTARVE_MAX, default 4: consecutive dcache grants allowed while iREN is pending, before the icache is forced ahead (used only with MEMARB_FAIR_EN).
REQ-002 SHALL have port CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port nRST  in  1  asynchronous, active-low reset.
REQ-004 SHALL have ports iREN in 1, iaddr in 32: icache fetch request and word address.
REQ-005 SHALL have ports iwait out 1, iload out 32: icache stall and returned word.
REQ-006 SHALL have ports dREN in 1, dWEN in 1, daddr in 32, dstore in 32: dcache read/write request, address and write data.
REQ-007 SHALL have ports dwait out 1, dload out 32: dcache stall and returned word.
REQ-008 SHALL have ports ramREN out 1, ramWEN out 1, ramaddr out 32, ramstore out 32, ramload in 32, ramstate in ramstate_t (FREE, BUSY, ACCESS, ERROR).

Function
REQ-009 SHALL be a 4-state FSM: IDLE, GNT_I, GNT_DR, GNT_DW.
REQ-010 In IDLE, SHALL pick the next grant from requests sampled at the clock edge: dWEN -> GNT_DW, else dREN -> GNT_DR, else iREN -> GNT_I, else stay in IDLE. This gives one cycle of arbitration latency.
REQ-011 If dWEN and dREN are both high, SHALL treat the request as a write.
REQ-012 In IDLE, SHALL drive ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1.
REQ-013 In GNT_I, SHALL drive ramREN=1, ramaddr=iaddr. In GNT_DR, SHALL drive ramREN=1, ramaddr=daddr. In GNT_DW, SHALL drive ramWEN=1, ramaddr=daddr, ramstore=dstore.
REQ-014 SHALL drive the granted requester's wait low combinationally only in a cycle where ramstate==ACCESS; that wait SHALL be 1 in every other cycle.
REQ-015 SHALL hold the non-granted requester's wait at 1 throughout the grant.
REQ-016 On an ACCESS cycle, SHALL return to IDLE at the next edge; back-to-back requests from the same cache therefore each cost at least 2 cycles.
REQ-017 On BUSY or ERROR, SHALL hold the grant and keep RAM signals stable; ERROR is retried and never completes.
REQ-018 If the granted request deasserts mid-grant (abort), SHALL return to IDLE at the next edge with no wait pulse, including when the same cycle shows ACCESS.
REQ-019 SHALL drive iload=ramload and dload=ramload as passthroughs; data is valid only while the matching wait is 0.
REQ-020 Address and store data SHALL be 32-bit passthroughs with no arithmetic or truncation.

Reset
REQ-021 While nRST=0, SHALL hold state=IDLE and the starvation counter at 0, with all outputs at the IDLE values of REQ-012.
REQ-022 Reset asserted mid-grant SHALL abandon the access immediately (ramREN and ramWEN go low asynchronously); it is not resumed after reset is released.

Configuration
REQ-023 Macro MEMARB_FAIR_EN defined: SHALL keep a counter of consecutive dcache grants issued while iREN is high. When the counter equals ISTARVE_MAX and iREN is high in IDLE, SHALL grant GNT_I. The counter SHALL clear on any icache grant and whenever iREN is low in IDLE, and SHALL saturate at ISTARVE_MAX.
REQ-024 Macro MEMARB_FAIR_EN undefined: SHALL use strict dcache-first priority per REQ-010, with no counter logic present.

Structure
REQ-025 memarb_state_t (IDLE, GNT_I, GNT_DR, GNT_DW) SHALL live in cpu_types_pkg next to the existing ramstate_t.
REQ-026 Grant selection and the starvation counter SHALL be one sub-module, memarb_select, which outputs the next state from IDLE; the FSM and output muxing stay in memory_arbiter.

Verification
REQ-027 Only iREN=1, iaddr=0x40, RAM gives BUSY then ACCESS with ramload=0x8C010004 -> GNT_I entered 1 cycle after the request; iwait=0 with iload=0x8C010004 exactly in the ACCESS cycle; IDLE on the next cycle.
REQ-028 iREN=1 and dREN=1 raised in the same cycle -> dcache served first; icache granted only after dcache's ACCESS cycle plus the IDLE cycle; iwait stays 1 during the dcache grant.
REQ-029 dREN=1 and dWEN=1, daddr=0x100, dstore=0xDEADBEEF -> ramWEN=1, ramREN=0, ramstore=0xDEADBEEF; dwait=0 exactly on ACCESS.
REQ-030 Mid-GNT_DR, dREN dropped while ramstate=BUSY -> IDLE next cycle; dwait never pulses low.
REQ-031 With MEMARB_FAIR_EN and ISTARVE_MAX=4, continuous dREN and iREN -> the 5th grant goes to the icache; without the macro, the icache is never granted.
REQ-032 nRST pulsed low during GNT_DW -> ramWEN drops immediately; after release, state is IDLE with iwait=1 and dwait=1.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: RAM handshake state and memory arbiter FSM states.
// Arbiter states are plain localparams so legacy code can compare them.
package cpu_types_pkg;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef logic [1:0] memarb_state_t;

    localparam memarb_state_t IDLE   = 2'd0;
    localparam memarb_state_t GNT_I  = 2'd1;
    localparam memarb_state_t GNT_DR = 2'd2;
    localparam memarb_state_t GNT_DW = 2'd3;

endpackage

// File: rtl/memory_arbiter_if.sv
// Cache/RAM bus bundle for the memory arbiter.
// slave = arbiter side, master = caches plus RAM side.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        dwait;
    logic [31:0] dload;

    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore,
        input  ramload, ramstate,
        output iwait, iload, dwait, dload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore,
        output ramload, ramstate,
        input  iwait, iload, dwait, dload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/memarb_select.sv
// Next-grant selection out of IDLE for the memory arbiter.
// MEMARB_FAIR_EN adds an icache starvation counter (ISTARVE_MAX).
module memarb_select
    import cpu_types_pkg::*;
`ifdef MEMARB_FAIR_EN
#(
    parameter int ISTARVE_MAX = 4
)
`endif
(
`ifdef MEMARB_FAIR_EN
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          idle_i,
`endif
    input  logic          iren_i,
    input  logic          dren_i,
    input  logic          dwen_i,
    output memarb_state_t next_o
);

`ifdef MEMARB_FAIR_EN
    localparam int CW = $clog2(ISTARVE_MAX + 1);
    localparam logic [CW-1:0] MAXC = CW'(ISTARVE_MAX);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          starved;

    assign starved = iren_i && (cnt_q == MAXC);

    // Grant choice: starved icache first, then write, read, fetch.
    always_comb begin
        next_o = IDLE;
        if (starved)     next_o = GNT_I;
        else if (dwen_i) next_o = GNT_DW;
        else if (dren_i) next_o = GNT_DR;
        else if (iren_i) next_o = GNT_I;
    end

    // Count dcache grants taken while the icache waits; saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (idle_i) begin
            if (!iren_i)
                cnt_d = '0;
            else if (next_o == GNT_I)
                cnt_d = '0;
            else if (cnt_q != MAXC)
                cnt_d = cnt_q + 1'b1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
`else
    // Strict dcache-first priority; a write wins over a read.
    always_comb begin
        next_o = IDLE;
        if (dwen_i)      next_o = GNT_DW;
        else if (dren_i) next_o = GNT_DR;
        else if (iren_i) next_o = GNT_I;
    end
`endif

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between icache and dcache.
// Optional icache anti-starvation enabled by MEMARB_FAIR_EN.
module memory_arbiter
    import cpu_types_pkg::*;
#(
    parameter int ISTARVE_MAX = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    memory_arbiter_if.slave  bus
);

    if (ISTARVE_MAX < 1) begin : g_cfg_check
        $error("ISTARVE_MAX must be at least 1");
    end

    memarb_state_t state_q;
    memarb_state_t state_d;
    memarb_state_t sel_next;
    logic          ram_acc;

    assign ram_acc = (bus.ramstate == ACCESS);

`ifdef MEMARB_FAIR_EN
    memarb_select #(
        .ISTARVE_MAX (ISTARVE_MAX)
    ) u_select (
        .clk_i  (CLK),
        .rst_ni (nRST),
        .idle_i (state_q == IDLE),
        .iren_i (bus.iREN),
        .dren_i (bus.dREN),
        .dwen_i (bus.dWEN),
        .next_o (sel_next)
    );
`else
    memarb_select u_select (
        .iren_i (bus.iREN),
        .dren_i (bus.dREN),
        .dwen_i (bus.dWEN),
        .next_o (sel_next)
    );
`endif

    // Next state: leave a grant on ACCESS or when the request drops.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:   state_d = sel_next;
            GNT_I:  if (!bus.iREN || ram_acc) state_d = IDLE;
            GNT_DR: if (!bus.dREN || ram_acc) state_d = IDLE;
            GNT_DW: if (!bus.dWEN || ram_acc) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any access in flight.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // RAM and cache-side outputs; wait only drops for a live request.
    always_comb begin
        bus.ramREN   = 1'b0;
        bus.ramWEN   = 1'b0;
        bus.ramaddr  = '0;
        bus.ramstore = '0;
        bus.iwait    = 1'b1;
        bus.dwait    = 1'b1;
        unique case (state_q)
            IDLE: ;
            GNT_I: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.iaddr;
                bus.iwait   = !(bus.iREN && ram_acc);
            end
            GNT_DR: begin
                bus.ramREN  = 1'b1;
                bus.ramaddr = bus.daddr;
                bus.dwait   = !(bus.dREN && ram_acc);
            end
            GNT_DW: begin
                bus.ramWEN   = 1'b1;
                bus.ramaddr  = bus.daddr;
                bus.ramstore = bus.dstore;
                bus.dwait    = !(bus.dWEN && ram_acc);
            end
            default: ;
        endcase
    end

    assign bus.iload = bus.ramload;
    assign bus.dload = bus.ramload;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: directed table, corner sequences,
// and a randomized run against a grant-ownership model.
module tb_memory_arbiter;
    import cpu_types_pkg::*;

    localparam int IMAX = 4;
`ifdef MEMARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic CLK = 1'b0;
    logic nRST;
    always #5 CLK = ~CLK;

    memory_arbiter_if bus ();

    memory_arbiter #(
        .ISTARVE_MAX (IMAX)
    ) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        i, d, w;
        ramstate_t   rs;
        logic        ren, wen, iw, dw;
        logic [31:0] addr, store;
    } vec_t;

    vec_t tbl [22];

    // owner: 0 nobody, 1 icache, 2 dcache read, 3 dcache write
    int m_own;
    int m_cnt;

    task automatic chk(input string nm, input logic [159:0] act,
                       input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [159:0] pack(
        logic ren, logic wen, logic iw, logic dw,
        logic [31:0] addr, logic [31:0] store,
        logic [31:0] il, logic [31:0] dl);
        return {28'd0, ren, wen, iw, dw, addr, store, il, dl};
    endfunction

    function automatic logic [159:0] obs();
        return pack(bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait,
                    bus.ramaddr, bus.ramstore, bus.iload, bus.dload);
    endfunction

    function automatic vec_t mk(logic i, logic d, logic w, ramstate_t rs,
                                logic ren, logic wen, logic iw, logic dw,
                                logic [31:0] addr, logic [31:0] store);
        vec_t v;
        v.i = i; v.d = d; v.w = w; v.rs = rs;
        v.ren = ren; v.wen = wen; v.iw = iw; v.dw = dw;
        v.addr = addr; v.store = store;
        return v;
    endfunction

    // Expected outputs from who owns the RAM and whether that owner's
    // request is still up during an ACCESS cycle.
    function automatic logic [159:0] model_exp();
        logic acc;
        logic [31:0] ld;
        acc = (bus.ramstate == ACCESS);
        ld  = bus.ramload;
        case (m_own)
            1: return pack(1, 0, !(bus.iREN && acc), 1,
                           bus.iaddr, 0, ld, ld);
            2: return pack(1, 0, 1, !(bus.dREN && acc),
                           bus.daddr, 0, ld, ld);
            3: return pack(0, 1, 1, !(bus.dWEN && acc),
                           bus.daddr, bus.dstore, ld, ld);
            default: return pack(0, 0, 1, 1, 0, 0, ld, ld);
        endcase
    endfunction

    // Ownership changes at a clock edge.
    task automatic model_step();
        logic acc;
        acc = (bus.ramstate == ACCESS);
        case (m_own)
            0: begin
                if (FAIR && bus.iREN && m_cnt == IMAX) m_own = 1;
                else if (bus.dWEN) m_own = 3;
                else if (bus.dREN) m_own = 2;
                else if (bus.iREN) m_own = 1;
                if (!bus.iREN || m_own == 1) m_cnt = 0;
                else if (m_own >= 2 && m_cnt < IMAX) m_cnt++;
            end
            1: if (!bus.iREN || acc) m_own = 0;
            2: if (!bus.dREN || acc) m_own = 0;
            3: if (!bus.dWEN || acc) m_own = 0;
            default: m_own = 0;
        endcase
    endtask

    initial begin
        logic [31:0] grants [10];
        int ng;
        logic [31:0] want;

        tbl[0]  = mk(1, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[1]  = mk(1, 0, 0, BUSY,   1, 0, 1, 1, 32'h40,  32'h0);
        tbl[2]  = mk(1, 0, 0, ACCESS, 1, 0, 0, 1, 32'h40,  32'h0);
        tbl[3]  = mk(0, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[4]  = mk(1, 1, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[5]  = mk(1, 1, 0, BUSY,   1, 0, 1, 1, 32'h100, 32'h0);
        tbl[6]  = mk(1, 1, 0, ACCESS, 1, 0, 1, 0, 32'h100, 32'h0);
        tbl[7]  = mk(1, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[8]  = mk(1, 0, 0, ACCESS, 1, 0, 0, 1, 32'h40,  32'h0);
        tbl[9]  = mk(0, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[10] = mk(0, 1, 1, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[11] = mk(0, 1, 1, BUSY,   0, 1, 1, 1, 32'h100, 32'hDEADBEEF);
        tbl[12] = mk(0, 1, 1, ACCESS, 0, 1, 1, 0, 32'h100, 32'hDEADBEEF);
        tbl[13] = mk(0, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[14] = mk(0, 1, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[15] = mk(0, 1, 0, BUSY,   1, 0, 1, 1, 32'h100, 32'h0);
        tbl[16] = mk(0, 0, 0, BUSY,   1, 0, 1, 1, 32'h100, 32'h0);
        tbl[17] = mk(0, 0, 0, ACCESS, 0, 0, 1, 1, 32'h0,   32'h0);
        tbl[18] = mk(0, 1, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);
        tbl[19] = mk(0, 1, 0, ERROR,  1, 0, 1, 1, 32'h100, 32'h0);
        tbl[20] = mk(0, 0, 0, ACCESS, 1, 0, 1, 1, 32'h100, 32'h0);
        tbl[21] = mk(0, 0, 0, FREE,   0, 0, 1, 1, 32'h0,   32'h0);

        nRST          = 1'b0;
        bus.iREN      = 1'b1;
        bus.dREN      = 1'b0;
        bus.dWEN      = 1'b1;
        bus.iaddr     = 32'h40;
        bus.daddr     = 32'h100;
        bus.dstore    = 32'hDEADBEEF;
        bus.ramload   = 32'h8C010004;
        bus.ramstate  = ACCESS;

        @(negedge CLK);
        chk("reset_idle", obs(),
            pack(0, 0, 1, 1, 0, 0, 32'h8C010004, 32'h8C010004));
        bus.iREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        @(negedge CLK);
        nRST = 1'b1;

        for (int k = 0; k < 22; k++) begin
            @(posedge CLK);
            #1;
            bus.iREN     = tbl[k].i;
            bus.dREN     = tbl[k].d;
            bus.dWEN     = tbl[k].w;
            bus.ramstate = tbl[k].rs;
            bus.ramload  = 32'h8C010004 + k;
            @(negedge CLK);
            chk($sformatf("vec%0d", k), obs(),
                pack(tbl[k].ren, tbl[k].wen, tbl[k].iw, tbl[k].dw,
                     tbl[k].addr, tbl[k].store,
                     32'h8C010004 + k, 32'h8C010004 + k));
        end

        // Reset pulse in the middle of a write grant.
        @(posedge CLK);
        #1;
        bus.dREN     = 1'b1;
        bus.dWEN     = 1'b1;
        bus.ramstate = BUSY;
        @(posedge CLK);
        @(negedge CLK);
        chk("rst_pre_wen", {159'd0, bus.ramWEN}, 160'd1);
        #1 nRST = 1'b0;
        #1;
        chk("rst_async_drop", {158'd0, bus.ramWEN, bus.ramREN}, 160'd0);
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = ACCESS;
        #1 nRST = 1'b1;
        #1;
        chk("rst_release_idle",
            {156'd0, bus.ramWEN, bus.ramREN, bus.iwait, bus.dwait},
            160'd3);
        @(negedge CLK);
        chk("rst_no_resume",
            {156'd0, bus.ramWEN, bus.ramREN, bus.iwait, bus.dwait},
            160'd3);

        // Continuous dcache read and icache fetch pressure.
        bus.iREN     = 1'b1;
        bus.dREN     = 1'b1;
        bus.ramstate = ACCESS;
        ng = 0;
        for (int c = 0; c < 60 && ng < 10; c++) begin
            @(negedge CLK);
            if (bus.ramREN) begin
                grants[ng] = bus.ramaddr;
                ng++;
            end
        end
        chk("fair_grant_count", 160'(ng), 160'd10);
        for (int g = 0; g < ng; g++) begin
            want = (FAIR && (g % (IMAX + 1)) == IMAX) ? 32'h40 : 32'h100;
            chk($sformatf("fair_grant%0d", g), 160'(grants[g]),
                160'(want));
        end

        // Randomized run from a clean reset.
        bus.iREN     = 1'b0;
        bus.dREN     = 1'b0;
        bus.dWEN     = 1'b0;
        bus.ramstate = FREE;
        #1 nRST = 1'b0;
        m_own = 0;
        m_cnt = 0;
        @(negedge CLK);
        nRST = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(posedge CLK);
            model_step();
            #1;
            if ($urandom_range(3) == 0) bus.iREN = ~bus.iREN;
            if ($urandom_range(3) == 0) bus.dREN = ~bus.dREN;
            if ($urandom_range(5) == 0) bus.dWEN = ~bus.dWEN;
            bus.ramstate = ramstate_t'($urandom_range(3));
            bus.iaddr    = $urandom;
            bus.daddr    = $urandom;
            bus.dstore   = $urandom;
            bus.ramload  = $urandom;
            @(negedge CLK);
            chk($sformatf("rand%0d", c), obs(), model_exp());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
